// File: rtl/trap_ctrl.sv
// Commit-stage trap controller: arbitrates interrupts, exceptions and mret at WB,
// then sequences the CSR update pulse and the front-end redirect.
module trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] pc_wb,
    input  logic [31:0] inst_wb,
    input  logic [31:0] addr_wb,
    input  logic        exc_illegal,
    input  logic        exc_ecall,
    input  logic        exc_lfault,
    input  logic        exc_sfault,
    input  logic        mret_wb,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic [31:0] mstatus,
    input  logic [31:0] mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_i,
    output logic        is_trap,
    output logic        is_mret,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [31:0] mtval,
    output logic        kill_wb,
    output logic        flush,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRAP  = 2'd1;
    localparam logic [1:0] S_MRET  = 2'd2;
    localparam logic [1:0] S_REDIR = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        ext_s1_q, ext_s1_d, ext_s2_q, ext_s2_d;
    logic        tmr_s1_q, tmr_s1_d, tmr_s2_q, tmr_s2_d;
    logic [31:0] epc_q, epc_d, cause_q, cause_d, tval_q, tval_d, tgt_q, tgt_d;

    logic        ext_pend, tmr_pend, take_trap, take_mret, is_irq;
    logic [31:0] cause_n, tval_n;

    logic unused_ok;
    assign unused_ok = ^{mstatus[31:4], mstatus[2:0], mie[31:12], mie[10:8], mie[6:0]};

    // Vectored mode only applies to interrupts; exceptions always go to the base.
    function automatic logic [31:0] trap_target(input logic [31:0] tvec,
                                                input logic        irq,
                                                input logic [31:0] cause);
        logic [31:0] base;
        base = {tvec[31:2], 2'b00};
        if (irq && tvec[1:0] == 2'b01)
            return base + {26'b0, cause[3:0], 2'b00};
        return base;
    endfunction

    always_comb begin
        ext_pend  = mstatus[3] & mie[11] & ext_s2_q;
        tmr_pend  = mstatus[3] & mie[7]  & tmr_s2_q;
        take_trap = 1'b0;
        take_mret = 1'b0;
        is_irq    = 1'b0;
        cause_n   = 32'd0;
        tval_n    = 32'd0;
        if (state_q == S_IDLE && inst_valid) begin
            if (ext_pend) begin
                take_trap = 1'b1; is_irq = 1'b1; cause_n = 32'h8000_000B;
            end else if (tmr_pend) begin
                take_trap = 1'b1; is_irq = 1'b1; cause_n = 32'h8000_0007;
            end else if (exc_illegal) begin
                take_trap = 1'b1; cause_n = 32'd2; tval_n = inst_wb;
            end else if (exc_ecall) begin
                take_trap = 1'b1; cause_n = 32'd11;
            end else if (exc_lfault) begin
                take_trap = 1'b1; cause_n = 32'd5; tval_n = addr_wb;
            end else if (exc_sfault) begin
                take_trap = 1'b1; cause_n = 32'd7; tval_n = addr_wb;
            end else if (mret_wb) begin
                take_mret = 1'b1;
            end
        end
    end

    always_comb begin
        ext_s1_d = irq_ext;
        ext_s2_d = ext_s1_q;
        tmr_s1_d = irq_timer;
        tmr_s2_d = tmr_s1_q;
        state_d  = state_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        tval_d   = tval_q;
        tgt_d    = tgt_q;
        case (state_q)
            S_IDLE: begin
                if (take_trap) begin
                    state_d = S_TRAP;
                    epc_d   = pc_wb;
                    cause_d = cause_n;
                    tval_d  = tval_n;
                    tgt_d   = trap_target(mtvec, is_irq, cause_n);
                end else if (take_mret) begin
                    state_d = S_MRET;
                    tgt_d   = mepc_i;
                end
            end
            S_TRAP, S_MRET: state_d = S_REDIR;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ext_s1_q <= 1'b0;
            ext_s2_q <= 1'b0;
            tmr_s1_q <= 1'b0;
            tmr_s2_q <= 1'b0;
            epc_q    <= 32'd0;
            cause_q  <= 32'd0;
            tval_q   <= 32'd0;
            tgt_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            ext_s1_q <= ext_s1_d;
            ext_s2_q <= ext_s2_d;
            tmr_s1_q <= tmr_s1_d;
            tmr_s2_q <= tmr_s2_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            tval_q   <= tval_d;
            tgt_q    <= tgt_d;
        end
    end

    // kill_wb is input-driven, so it is gated by reset explicitly.
    always_comb begin
        kill_wb     = take_trap & rst;
        is_trap     = (state_q == S_TRAP);
        is_mret     = (state_q == S_MRET);
        flush       = is_trap | is_mret;
        redirect    = (state_q == S_REDIR);
        stall       = flush | redirect;
        mepc        = is_mret ? mepc_i : epc_q;
        mcause      = cause_q;
        mtval       = tval_q;
        redirect_pc = redirect ? tgt_q : 32'd0;
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expected outputs are queued per cycle and
// compared against the DUT once the cycle's outputs have settled.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [31:0] pc_wb, inst_wb, addr_wb;
    logic        exc_illegal, exc_ecall, exc_lfault, exc_sfault, mret_wb;
    logic        irq_ext, irq_timer;
    logic [31:0] mstatus, mie, mtvec, mepc_i;
    logic        is_trap, is_mret, kill_wb, flush, stall, redirect;
    logic [31:0] mepc, mcause, mtval, redirect_pc;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    string fname[10] = '{"kill_wb", "is_trap", "is_mret", "flush", "stall",
                         "redirect", "redirect_pc", "mepc", "mcause", "mtval"};

    trap_ctrl dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid),
        .pc_wb(pc_wb), .inst_wb(inst_wb), .addr_wb(addr_wb),
        .exc_illegal(exc_illegal), .exc_ecall(exc_ecall),
        .exc_lfault(exc_lfault), .exc_sfault(exc_sfault), .mret_wb(mret_wb),
        .irq_ext(irq_ext), .irq_timer(irq_timer),
        .mstatus(mstatus), .mie(mie), .mtvec(mtvec), .mepc_i(mepc_i),
        .is_trap(is_trap), .is_mret(is_mret), .mepc(mepc), .mcause(mcause),
        .mtval(mtval), .kill_wb(kill_wb), .flush(flush), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs(int sel);
        case (sel)
            0: return {31'b0, kill_wb};
            1: return {31'b0, is_trap};
            2: return {31'b0, is_mret};
            3: return {31'b0, flush};
            4: return {31'b0, stall};
            5: return {31'b0, redirect};
            6: return redirect_pc;
            7: return mepc;
            8: return mcause;
            default: return mtval;
        endcase
    endfunction

    task automatic expect_all(input logic kill, input logic trap, input logic mret,
                              input logic fl, input logic st, input logic redir,
                              input logic [31:0] rpc, input logic [31:0] epc,
                              input logic [31:0] cause, input logic [31:0] tval,
                              input string tag);
        logic [31:0] v[10];
        v = '{{31'b0, kill}, {31'b0, trap}, {31'b0, mret}, {31'b0, fl}, {31'b0, st},
              {31'b0, redir}, rpc, epc, cause, tval};
        for (int i = 0; i < 10; i++) begin
            exp_t e;
            e.sel = i;
            e.val = v[i];
            e.tag = $sformatf("%s.%s", tag, fname[i]);
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] o;
            e = sb.pop_front();
            o = obs(e.sel);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_commit();
        inst_valid = 0; exc_illegal = 0; exc_ecall = 0; exc_lfault = 0;
        exc_sfault = 0; mret_wb = 0;
    endtask

    initial begin
        rst = 0;
        clear_commit();
        pc_wb = 0; inst_wb = 0; addr_wb = 0;
        irq_ext = 0; irq_timer = 0;
        mstatus = 0; mie = 0; mtvec = 32'h200; mepc_i = 0;
        #3;
        expect_all(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        drain();
        tick(); tick();
        rst = 1;
        expect_all(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle0");
        drain();

        // Illegal instruction
        tick();
        inst_valid = 1; exc_illegal = 1; pc_wb = 32'h100; inst_wb = 32'hFFFF_FFFF;
        expect_all(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "ill_acc");
        drain();
        tick();
        clear_commit();
        expect_all(0, 1, 0, 1, 1, 0, 0, 32'h100, 2, 32'hFFFF_FFFF, "ill_trap");
        drain();
        tick();
        expect_all(0, 0, 0, 0, 1, 1, 32'h200, 32'h100, 2, 32'hFFFF_FFFF, "ill_redir");
        drain();
        tick();
        expect_all(0, 0, 0, 0, 0, 0, 0, 32'h100, 2, 32'hFFFF_FFFF, "ill_idle");
        drain();

        // Priority: ecall over lfault, masked external irq ignored
        irq_ext = 1;
        tick(); tick(); tick();
        inst_valid = 1; exc_ecall = 1; exc_lfault = 1; pc_wb = 32'h140; addr_wb = 32'h55;
        expect_all(1, 0, 0, 0, 0, 0, 0, 32'h100, 2, 32'hFFFF_FFFF, "prio_acc");
        drain();
        tick();
        clear_commit(); irq_ext = 0;
        expect_all(0, 1, 0, 1, 1, 0, 0, 32'h140, 11, 0, "prio_trap");
        drain();
        tick();
        expect_all(0, 0, 0, 0, 1, 1, 32'h200, 32'h140, 11, 0, "prio_redir");
        drain();
        tick(); tick();

        // Vectored timer interrupt through the synchronizer
        mstatus = 32'h88; mie = 32'hFFF; mtvec = 32'h301;
        inst_valid = 1; pc_wb = 32'h400; irq_timer = 1;
        expect_all(0, 0, 0, 0, 0, 0, 0, 32'h140, 11, 0, "tmr_s0");
        drain();
        tick();
        expect_all(0, 0, 0, 0, 0, 0, 0, 32'h140, 11, 0, "tmr_s1");
        drain();
        tick();
        expect_all(1, 0, 0, 0, 0, 0, 0, 32'h140, 11, 0, "tmr_acc");
        drain();
        tick();
        clear_commit(); irq_timer = 0;
        expect_all(0, 1, 0, 1, 1, 0, 0, 32'h400, 32'h8000_0007, 0, "tmr_trap");
        drain();
        tick();
        expect_all(0, 0, 0, 0, 1, 1, 32'h31C, 32'h400, 32'h8000_0007, 0, "tmr_redir");
        drain();
        tick();
        mstatus = 0; mtvec = 32'h200;
        expect_all(0, 0, 0, 0, 0, 0, 0, 32'h400, 32'h8000_0007, 0, "tmr_idle");
        drain();

        // Mret: target sampled on entry, mepc follows mepc_i while in MRET
        tick();
        inst_valid = 1; mret_wb = 1; mepc_i = 32'h1234;
        expect_all(0, 0, 0, 0, 0, 0, 0, 32'h400, 32'h8000_0007, 0, "mret_acc");
        drain();
        tick();
        clear_commit();
        expect_all(0, 0, 1, 1, 1, 0, 0, 32'h1234, 32'h8000_0007, 0, "mret_st");
        drain();
        tick();
        mepc_i = 32'h9999;
        expect_all(0, 0, 0, 0, 1, 1, 32'h1234, 32'h400, 32'h8000_0007, 0, "mret_redir");
        drain();
        tick();
        expect_all(0, 0, 0, 0, 0, 0, 0, 32'h400, 32'h8000_0007, 0, "mret_idle");
        drain();

        // Back-to-back: held sfault is ignored outside IDLE, then retaken
        inst_valid = 1; exc_sfault = 1; pc_wb = 32'h500; addr_wb = 32'hA0;
        expect_all(1, 0, 0, 0, 0, 0, 0, 32'h400, 32'h8000_0007, 0, "b2b_acc1");
        drain();
        tick();
        pc_wb = 32'h504;
        expect_all(0, 1, 0, 1, 1, 0, 0, 32'h500, 7, 32'hA0, "b2b_trap1");
        drain();
        tick();
        expect_all(0, 0, 0, 0, 1, 1, 32'h200, 32'h500, 7, 32'hA0, "b2b_redir1");
        drain();
        tick();
        expect_all(1, 0, 0, 0, 0, 0, 0, 32'h500, 7, 32'hA0, "b2b_acc2");
        drain();
        tick();
        clear_commit();
        expect_all(0, 1, 0, 1, 1, 0, 0, 32'h504, 7, 32'hA0, "b2b_trap2");
        drain();
        tick();
        expect_all(0, 0, 0, 0, 1, 1, 32'h200, 32'h504, 7, 32'hA0, "b2b_redir2");
        drain();
        tick();
        expect_all(0, 0, 0, 0, 0, 0, 0, 32'h504, 7, 32'hA0, "b2b_idle");
        drain();

        // Reset during TRAP aborts the redirect
        inst_valid = 1; exc_illegal = 1; pc_wb = 32'h600; inst_wb = 32'h13;
        tick();
        expect_all(0, 1, 0, 1, 1, 0, 0, 32'h600, 2, 32'h13, "rst_trap");
        drain();
        rst = 0;
        expect_all(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_now");
        drain();
        tick();
        expect_all(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_held");
        drain();
        clear_commit();
        rst = 1;
        expect_all(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_rel");
        drain();
        tick();
        expect_all(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_noredir");
        drain();
        inst_valid = 1; exc_lfault = 1; pc_wb = 32'h700; addr_wb = 32'hBEEF;
        expect_all(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "post_acc");
        drain();
        tick();
        clear_commit();
        expect_all(0, 1, 0, 1, 1, 0, 0, 32'h700, 5, 32'hBEEF, "post_trap");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: inst_valid  in  1  instruction present at commit (WB) stage.
REQ-004 SHALL have: pc_wb  in  32; inst_wb  in  32; addr_wb  in  32 (memory address of the commit instruction).
REQ-005 SHALL have: exc_illegal, exc_ecall, exc_lfault, exc_sfault, mret_wb  in  1 each (commit-stage flags).
REQ-006 SHALL have: irq_ext, irq_timer  in  1  asynchronous interrupt requests.
REQ-007 SHALL have: mstatus, mie, mtvec, mepc_i  in  32  current CSR values.
REQ-008 SHALL have: is_trap, is_mret  out  1; mepc, mcause, mtval  out  32  (CSR update bus).
REQ-009 SHALL have: kill_wb, flush, stall, redirect  out  1; redirect_pc  out  32.

Function
REQ-010 SHALL pass irq_ext and irq_timer through 2-flop synchronizers; the FSM uses only the synchronized values.
REQ-011 SHALL treat an interrupt as pending when mstatus[3] & mie[11] & ext_sync (external) or mstatus[3] & mie[7] & tmr_sync (timer).
REQ-012 SHALL implement FSM states IDLE, TRAP, MRET, REDIR; reset state is IDLE.
REQ-013 In IDLE with inst_valid=1, SHALL accept events by priority: ext irq > timer irq > illegal > ecall > lfault > sfault > mret_wb.
REQ-014 SHALL encode cause/tval as: ext 0x8000000B/0; timer 0x80000007/0; illegal 2/inst_wb; ecall 11/0; lfault 5/addr_wb; sfault 7/addr_wb.
REQ-015 On accepting an interrupt or exception, SHALL latch epc=pc_wb and the cause/tval, assert kill_wb combinationally in that same cycle, and move to TRAP.
REQ-016 On accepting mret_wb, SHALL not assert kill_wb and SHALL move to MRET.
REQ-017 With inst_valid=0 or no event, SHALL stay in IDLE; all outputs are 0 except mepc/mcause/mtval, which hold their latched values.
REQ-018 TRAP SHALL last exactly 1 cycle: is_trap=1, flush=1, stall=1, mepc/mcause/mtval = latched values; next state REDIR.
REQ-019 MRET SHALL last exactly 1 cycle: is_mret=1, flush=1, stall=1, mepc=mepc_i, mcause/mtval = last latched values; next state REDIR.
REQ-020 REDIR SHALL last exactly 1 cycle: redirect=1, stall=1; next state IDLE.
REQ-021 For an mret, redirect_pc SHALL be mepc_i sampled on entering MRET.
REQ-022 For an interrupt with mtvec[1:0]=01, redirect_pc SHALL be {mtvec[31:2],2'b00} + 4*cause[3:0], computed mod 2^32.
REQ-023 For every other trap, redirect_pc SHALL be {mtvec[31:2],2'b00}.
REQ-024 redirect_pc SHALL be 0 whenever redirect=0.
REQ-025 Outside IDLE, SHALL ignore all commit and interrupt inputs; an interrupt still pending on return to IDLE is re-evaluated there.
REQ-026 Event-to-redirect latency SHALL be 2 cycles after the accept edge (accept edge -> TRAP/MRET -> REDIR).

Reset
REQ-027 While rst=0, SHALL force IDLE, clear both synchronizers, and drive all outputs and latched epc/cause/tval to 0.
REQ-028 Assertion of rst in any state, including TRAP, MRET or REDIR, SHALL abort the sequence with no pulse issued after reset; operation restarts in IDLE after release.

Verification
REQ-029 Illegal instruction: inst_valid=1, exc_illegal=1, pc_wb=0x100, inst_wb=0xFFFFFFFF, mtvec=0x200 -> kill_wb same cycle; next cycle is_trap=1 with mepc=0x100, mcause=2, mtval=0xFFFFFFFF; next cycle redirect=1 with redirect_pc=0x200.
REQ-030 Vectored timer interrupt: mstatus=0x88, mie=0xFFF, mtvec=0x301, irq_timer held high -> after 2 synchronizer cycles plus accept, mcause=0x80000007 and redirect_pc=0x31C.
REQ-031 Priority: exc_ecall=1 and exc_lfault=1 together -> mcause=11, mtval=0; with mstatus[3]=0 and irq_ext=1 -> ext is not taken and mcause=11.
REQ-032 Mret: mret_wb=1, mepc_i=0x1234 -> kill_wb=0; is_mret=1 for 1 cycle; then redirect=1 with redirect_pc=0x1234.
REQ-033 Back-to-back: new exception presented during TRAP/REDIR is ignored, then accepted in IDLE -> exactly two is_trap pulses, each separated by IDLE.
REQ-034 Reset mid-sequence: rst=0 during TRAP -> all outputs 0 immediately, no redirect pulse; after release, state is IDLE.
